// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWait
  } state_e;

  localparam int unsigned BYTE_W       = 8;
  localparam int unsigned BIT_CYCLES   = 2604;
  localparam int unsigned FRAME_CYCLES = 10 * BIT_CYCLES;

endpackage

// File: rtl/rr_picker.sv
// Round-robin pick: first set req bit strictly after last_gnt, wrapping modulo NUM_REQ.
module rr_picker #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_gnt,
  output logic                       gnt_valid,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [IdxW-1:0]      start;
  logic [IdxW-1:0]      offset;
  logic [IdxW:0]        sum;

  always_comb begin
    start   = (last_gnt == IdxW'(NUM_REQ - 1)) ? '0 : last_gnt + IdxW'(1);
    // Doubling the vector turns the rotation into a plain part-select.
    req_dbl = {req, req};
    req_rot = req_dbl[start +: NUM_REQ];
    offset  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) offset = IdxW'(k);
    end
    sum = {1'b0, start} + {1'b0, offset};
    if (sum >= (IdxW + 1)'(NUM_REQ)) sum = sum - (IdxW + 1)'(NUM_REQ);
    gnt_idx   = sum[IdxW-1:0];
    gnt_valid = |req;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte producers with round-robin grants,
// completion reporting and a per-byte watchdog.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 32768
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [BYTE_W*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]          ack,
  output logic [NUM_REQ-1:0]          done,
  output logic [$clog2(NUM_REQ)-1:0]  gnt_id,
  output logic                        busy,
  output logic                        timeout_err,
  output logic                        trmt,
  output logic [BYTE_W-1:0]           tx_data,
  input  logic                        tx_done
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT_CYCLES - 1);

  state_e              state_q, state_d;
  logic [IdxW-1:0]     gnt_id_q, gnt_id_d;
  logic [IdxW-1:0]     last_gnt_q, last_gnt_d;
  logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic                timeout_err_q, timeout_err_d;
  logic                tx_done_q;
  logic [TmrW-1:0]     timer_q, timer_d;

  logic                pick_valid;
  logic [IdxW-1:0]     pick_idx;
  logic [BYTE_W-1:0]   req_bytes [NUM_REQ];
  logic                tx_done_rise;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_picker (
    .req       (req),
    .last_gnt  (last_gnt_q),
    .gnt_valid (pick_valid),
    .gnt_idx   (pick_idx)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_bytes[i] = req_data[BYTE_W*i +: BYTE_W];
    end
  end

  assign tx_done_rise = tx_done & ~tx_done_q;

  always_comb begin
    state_d       = state_q;
    gnt_id_d      = gnt_id_q;
    last_gnt_d    = last_gnt_q;
    tx_data_d     = tx_data_q;
    timer_d       = timer_q;
    ack_d         = '0;
    done_d        = '0;
    timeout_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d         = StStart;
          gnt_id_d        = pick_idx;
          tx_data_d       = req_bytes[pick_idx];
          ack_d[pick_idx] = 1'b1;
        end
      end
      StStart: begin
        timer_d = '0;
        state_d = StWait;
      end
      StWait: begin
        timer_d = timer_q + TmrW'(1);
        // A completion on the last allowed cycle still counts as success.
        if (tx_done_rise) begin
          done_d[gnt_id_q] = 1'b1;
          last_gnt_d       = gnt_id_q;
          state_d          = StIdle;
        end else if (timer_q == TmrLast) begin
          timeout_err_d = 1'b1;
          last_gnt_d    = gnt_id_q;
          state_d       = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      gnt_id_q      <= '0;
      last_gnt_q    <= IdxW'(NUM_REQ - 1);
      tx_data_q     <= '0;
      ack_q         <= '0;
      done_q        <= '0;
      timeout_err_q <= 1'b0;
      tx_done_q     <= 1'b0;
      timer_q       <= '0;
    end else begin
      state_q       <= state_d;
      gnt_id_q      <= gnt_id_d;
      last_gnt_q    <= last_gnt_d;
      tx_data_q     <= tx_data_d;
      ack_q         <= ack_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
      tx_done_q     <= tx_done;
      timer_q       <= timer_d;
    end
  end

  assign ack         = ack_q;
  assign done        = done_q;
  assign gnt_id      = gnt_id_q;
  assign tx_data     = tx_data_q;
  assign timeout_err = timeout_err_q;
  assign busy        = (state_q != StIdle);
  assign trmt        = (state_q == StStart);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter against a transaction-level round-robin model.
module tb_uart_tx_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned TO = 100;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   ack;
  logic [NR-1:0]   done;
  logic [1:0]      gnt_id;
  logic            busy;
  logic            timeout_err;
  logic            trmt;
  logic [7:0]      tx_data;
  logic            tx_done;

  int n_vec = 0;
  int n_err = 0;
  int last_gnt;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ        (NR),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .done        (done),
    .gnt_id      (gnt_id),
    .busy        (busy),
    .timeout_err (timeout_err),
    .trmt        (trmt),
    .tx_data     (tx_data),
    .tx_done     (tx_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [NR-1:0] mask, input int last);
    for (int off = 1; off <= NR; off++) begin
      int i;
      i = (last + off) % NR;
      if (mask[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [NR-1:0] onehot(input int i);
    logic [NR-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Entered at the negedge of an IDLE cycle with req already driven; returns at the
  // negedge of the cycle carrying the done/timeout pulse. k < 0 means tx_done never rises.
  task automatic do_txn(input int k, input bit level, input bit drop);
    int         g;
    int         last_c;
    logic [7:0] b;
    g = rr_pick(req, last_gnt);
    b = req_data[8*g +: 8];
    @(negedge clk);
    check_eq("start_ack", 32'(ack), 32'(onehot(g)));
    check_eq("start_trmt", 32'(trmt), 32'd1);
    check_eq("start_data", 32'(tx_data), 32'(b));
    check_eq("start_gnt_id", 32'(gnt_id), 32'(g));
    check_eq("start_busy", 32'(busy), 32'd1);
    if (drop) req[g] = 1'b0;
    tx_done = 1'b0;
    last_c = (k < 0) ? int'(TO) - 1 : k;
    for (int c = 0; c <= last_c; c++) begin
      @(negedge clk);
      if (!level) tx_done = 1'b0;
      check_eq("wait_flags", 32'({ack, done, timeout_err, trmt, busy}), 32'd1);
      check_eq("wait_data", 32'(tx_data), 32'(b));
      if (c == k) tx_done = 1'b1;
    end
    @(negedge clk);
    if (!level) tx_done = 1'b0;
    check_eq("end_done", 32'(done), (k >= 0) ? 32'(onehot(g)) : 32'd0);
    check_eq("end_timeout", 32'(timeout_err), (k < 0) ? 32'd1 : 32'd0);
    check_eq("end_idle", 32'({ack, trmt, busy}), 32'd0);
    last_gnt = g;
  endtask

  initial begin
    logic [NR-1:0] newb;
    int            r;
    int            k;
    rst      = 1'b1;
    req      = '0;
    req_data = '0;
    tx_done  = 1'b0;
    last_gnt = NR - 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_flags", 32'({ack, done, timeout_err, trmt, busy}), 32'd0);
    check_eq("rst_data", 32'(tx_data), 32'h00);
    check_eq("rst_gnt_id", 32'(gnt_id), 32'd0);
    rst = 1'b0;

    // Single request from requester 2.
    req_data[23:16] = 8'h2A;
    req             = 4'b0100;
    do_txn(5, 1'b0, 1'b1);

    // All four held high: each gets one turn in rotation.
    req_data = {8'h0F, 8'h55, 8'hF1, 8'hB3};
    req      = 4'b1111;
    for (int n = 0; n < 5; n++) do_txn(n + 1, n[0], 1'b0);

    // Fairness: after a grant to 0, requester 3 goes first, then 0.
    req = 4'b0001;
    do_txn(2, 1'b0, 1'b1);
    req = 4'b1001;
    do_txn(3, 1'b1, 1'b1);
    do_txn(1, 1'b0, 1'b1);

    // Timeout, then completion on the very last WAIT cycle.
    req = 4'b0010;
    do_txn(-1, 1'b0, 1'b1);
    req = 4'b0100;
    do_txn(int'(TO) - 1, 1'b0, 1'b1);

    for (int it = 0; it < 30; it++) begin
      newb = NR'($urandom_range(0, (1 << NR) - 1));
      for (int i = 0; i < NR; i++) begin
        if (newb[i] && !req[i]) req_data[8*i +: 8] = 8'($urandom);
      end
      req = req | newb;
      if (req == '0) begin
        @(negedge clk);
        check_eq("idle_stay", 32'({ack, trmt, busy}), 32'd0);
      end else begin
        r = int'($urandom_range(0, 9));
        if (r == 0) k = -1;
        else if (r == 1) k = int'(TO) - 1;
        else k = int'($urandom_range(0, 20));
        do_txn(k, 1'($urandom_range(0, 1)), 1'b1);
      end
    end

    // Reset in the middle of WAIT.
    tx_done         = 1'b0;
    req_data[15:8]  = 8'hF1;
    req             = 4'b0010;
    @(negedge clk);
    check_eq("mid_ack", 32'(ack), 32'(onehot(1)));
    req = '0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_flags", 32'({ack, done, timeout_err, trmt, busy}), 32'd0);
    check_eq("mid_rst_data", 32'(tx_data), 32'h00);
    rst      = 1'b0;
    last_gnt = NR - 1;
    @(negedge clk);
    check_eq("post_rst_quiet", 32'({ack, done, timeout_err, trmt, busy}), 32'd0);
    req_data[7:0]   = 8'h3C;
    req_data[31:24] = 8'hC3;
    req             = 4'b1011;
    do_txn(4, 1'b0, 1'b1);
    check_eq("post_rst_prio", 32'(last_gnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
